axi_burst_mem_slave: RTL and testbench

Memory-backed AXI-style responder for the existing `Master`: it accepts write bursts on AW/W, returns a write response on B, and serves read bursts on AR/R from an internal byte array. It sits on the far end of the master's channels as a self-contained responder that keeps real storage. It gives the master bench a memory model whose data readback can be checked. One transaction is in flight at a time.

---
 rtl/axi_pkg.sv | 17 +
 rtl/burst_mem_ram.sv | 25 ++
 rtl/axi_burst_mem_slave.sv | 134 +++++++++++++
 tb/tb_axi_burst_mem_slave.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared definitions for the burst memory responder: response codes, FSM states, bus widths.
package axi_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    StIdle,
    StWBurst,
    StWResp,
    StRBurst
  } state_e;

endpackage

// File: rtl/burst_mem_ram.sv
// Byte-wide storage: one synchronous write port, one asynchronous read port, no reset.
module burst_mem_ram #(
  parameter int unsigned Depth = 256,
  parameter int unsigned AddrW = 8,
  parameter int unsigned DataW = 8
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [DataW-1:0] wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [DataW-1:0] rdata_o
);

  logic [DataW-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/axi_burst_mem_slave.sv
// Single-outstanding AXI-style responder backed by real storage; writes win over reads in IDLE.
module axi_burst_mem_slave
  import axi_pkg::*;
#(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned IDW   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              AWVALID,
  output logic              AWREADY,
  input  logic [ADDR_W-1:0] AWADDR,
  input  logic [IDW-1:0]    AWID,
  input  logic              WVALID,
  output logic              WREADY,
  input  logic [DATA_W-1:0] WDATA,
  input  logic              WLAST,
  output logic              BVALID,
  input  logic              BREADY,
  output logic [1:0]        BRESP,
  output logic [IDW-1:0]    BID,
  input  logic              ARVALID,
  output logic              ARREADY,
  input  logic [ADDR_W-1:0] ARADDR,
  input  logic [3:0]        ARLEN,
  input  logic [IDW-1:0]    ARID,
  output logic              RVALID,
  input  logic              RREADY,
  output logic [DATA_W-1:0] RDATA,
  output logic              RLAST,
  output logic [1:0]        RRESP,
  output logic [IDW-1:0]    RID
);

  localparam int unsigned MemAw = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] AddrMask = ADDR_W'(DEPTH - 1);

  state_e              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [IDW-1:0]      id_q;
  logic                err_q;
  logic [3:0]          beats_q;
  logic [DATA_W-1:0]   rdata_q;

  logic [ADDR_W-1:0]   addr_inc;
  logic [MemAw-1:0]    raddr;
  logic [DATA_W-1:0]   mem_rdata;
  logic                mem_we;
  logic                aw_err;
  logic                ar_err;

  assign addr_inc = (addr_q + ADDR_W'(1)) & AddrMask;
  assign aw_err   = 32'(AWADDR) >= DEPTH;
  assign ar_err   = 32'(ARADDR) >= DEPTH;
  assign mem_we   = (state_q == StWBurst) && WVALID && !err_q && !rst;
  // In IDLE the read port previews the AR target so beat 0 can be registered at the handshake.
  assign raddr    = (state_q == StIdle) ? ARADDR[MemAw-1:0] : addr_inc[MemAw-1:0];

  burst_mem_ram #(
    .Depth(DEPTH),
    .AddrW(MemAw),
    .DataW(DATA_W)
  ) u_ram (
    .clk_i  (clk),
    .we_i   (mem_we),
    .waddr_i(addr_q[MemAw-1:0]),
    .wdata_i(WDATA),
    .raddr_i(raddr),
    .rdata_o(mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      id_q    <= '0;
      err_q   <= 1'b0;
      beats_q <= '0;
      rdata_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (AWVALID) begin
            addr_q  <= AWADDR;
            id_q    <= AWID;
            err_q   <= aw_err;
            state_q <= StWBurst;
          end else if (ARVALID) begin
            addr_q  <= ARADDR;
            id_q    <= ARID;
            err_q   <= ar_err;
            beats_q <= ARLEN;
            rdata_q <= ar_err ? '0 : mem_rdata;
            state_q <= StRBurst;
          end
        end
        StWBurst: begin
          if (WVALID) begin
            addr_q <= addr_inc;
            if (WLAST) state_q <= StWResp;
          end
        end
        StWResp: begin
          if (BREADY) state_q <= StIdle;
        end
        StRBurst: begin
          if (RREADY) begin
            if (beats_q == 4'd0) begin
              state_q <= StIdle;
            end else begin
              beats_q <= beats_q - 4'd1;
              addr_q  <= addr_inc;
              rdata_q <= err_q ? '0 : mem_rdata;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign AWREADY = (state_q == StIdle);
  assign ARREADY = (state_q == StIdle) && !AWVALID;
  assign WREADY  = (state_q == StWBurst);
  assign BVALID  = (state_q == StWResp);
  assign BRESP   = (BVALID && err_q) ? RESP_SLVERR : RESP_OKAY;
  assign BID     = id_q;
  assign RVALID  = (state_q == StRBurst);
  assign RDATA   = rdata_q;
  assign RLAST   = RVALID && (beats_q == 4'd0);
  assign RRESP   = (RVALID && err_q) ? RESP_SLVERR : RESP_OKAY;
  assign RID     = id_q;

endmodule

// File: tb/tb_axi_burst_mem_slave.sv
// Drives a 256-deep and a 128-deep responder with shared stimulus; checks each against directed data.
module tb_axi_burst_mem_slave;

  localparam logic [1:0] OK  = 2'b00;
  localparam logic [1:0] ERR = 2'b10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic AWVALID = 0, WVALID = 0, WLAST = 0, BREADY = 0, ARVALID = 0, RREADY = 0;
  logic [7:0] AWADDR = '0, WDATA = '0, ARADDR = '0;
  logic [3:0] AWID = '0, ARID = '0, ARLEN = '0;

  logic awready, arready, wready, bvalid, rvalid, rlast;
  logic [1:0] bresp, rresp;
  logic [3:0] bid, rid;
  logic [7:0] rdata;
  logic awready_s, arready_s, wready_s, bvalid_s, rvalid_s, rlast_s;
  logic [1:0] bresp_s, rresp_s;
  logic [3:0] bid_s, rid_s;
  logic [7:0] rdata_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axi_burst_mem_slave #(.DEPTH(256), .IDW(4)) dut (
    .clk(clk), .rst(rst),
    .AWVALID(AWVALID), .AWREADY(awready), .AWADDR(AWADDR), .AWID(AWID),
    .WVALID(WVALID), .WREADY(wready), .WDATA(WDATA), .WLAST(WLAST),
    .BVALID(bvalid), .BREADY(BREADY), .BRESP(bresp), .BID(bid),
    .ARVALID(ARVALID), .ARREADY(arready), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARID(ARID),
    .RVALID(rvalid), .RREADY(RREADY), .RDATA(rdata), .RLAST(rlast), .RRESP(rresp), .RID(rid)
  );

  axi_burst_mem_slave #(.DEPTH(128), .IDW(4)) dut_s (
    .clk(clk), .rst(rst),
    .AWVALID(AWVALID), .AWREADY(awready_s), .AWADDR(AWADDR), .AWID(AWID),
    .WVALID(WVALID), .WREADY(wready_s), .WDATA(WDATA), .WLAST(WLAST),
    .BVALID(bvalid_s), .BREADY(BREADY), .BRESP(bresp_s), .BID(bid_s),
    .ARVALID(ARVALID), .ARREADY(arready_s), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARID(ARID),
    .RVALID(rvalid_s), .RREADY(RREADY), .RDATA(rdata_s), .RLAST(rlast_s), .RRESP(rresp_s),
    .RID(rid_s)
  );

  typedef struct {
    bit         s;     // 1: check the 128-deep instance
    bit         wr;
    logic [7:0] addr;
    logic [3:0] id;
    logic [3:0] len;
    logic [31:0] d;
    logic [1:0] resp;
  } vec_t;

  vec_t vecs[10];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_write(input vec_t v);
    AWADDR = v.addr; AWID = v.id; AWVALID = 1'b1;
    #1;
    for (int i = 0; i < 20 && !awready; i++) step();
    chk("awready", awready, 1);
    step();
    AWVALID = 1'b0;
    for (int k = 0; k <= int'(v.len); k++) begin
      WVALID = 1'b1; WDATA = v.d[8*k +: 8]; WLAST = (k == int'(v.len));
      chk("wready", v.s ? wready_s : wready, 1);
      step();
    end
    WVALID = 1'b0; WLAST = 1'b0;
    chk("bvalid", v.s ? bvalid_s : bvalid, 1);
    chk("bresp", v.s ? bresp_s : bresp, v.resp);
    chk("bid", v.s ? bid_s : bid, v.id);
    BREADY = 1'b1;
    step();
    BREADY = 1'b0;
    chk("bvalid_drop", v.s ? bvalid_s : bvalid, 0);
  endtask

  task automatic do_read(input vec_t v);
    ARADDR = v.addr; ARID = v.id; ARLEN = v.len; ARVALID = 1'b1;
    #1;
    for (int i = 0; i < 20 && !arready; i++) step();
    chk("arready", arready, 1);
    step();
    ARVALID = 1'b0; RREADY = 1'b1;
    for (int k = 0; k <= int'(v.len); k++) begin
      chk("rvalid", v.s ? rvalid_s : rvalid, 1);
      chk("rdata", v.s ? rdata_s : rdata, v.d[8*k +: 8]);
      chk("rlast", v.s ? rlast_s : rlast, (k == int'(v.len)) ? 1 : 0);
      chk("rresp", v.s ? rresp_s : rresp, v.resp);
      chk("rid", v.s ? rid_s : rid, v.id);
      step();
    end
    RREADY = 1'b0;
    chk("rvalid_drop", v.s ? rvalid_s : rvalid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{0, 1, 8'h01, 4'h1, 4'd2, 32'h00030201, OK};
    vecs[1] = '{0, 0, 8'h01, 4'h1, 4'd2, 32'h00030201, OK};
    vecs[2] = '{0, 1, 8'hFE, 4'h5, 4'd2, 32'h00332211, OK};
    vecs[3] = '{0, 0, 8'hFE, 4'h6, 4'd2, 32'h00332211, OK};
    vecs[4] = '{1, 1, 8'd72, 4'h1, 4'd0, 32'h00000048, OK};
    vecs[5] = '{1, 1, 8'd200, 4'h7, 4'd0, 32'h000000EE, ERR};
    vecs[6] = '{1, 0, 8'd200, 4'h8, 4'd0, 32'h00000000, ERR};
    vecs[7] = '{1, 0, 8'd72, 4'h2, 4'd0, 32'h00000048, OK};
    vecs[8] = '{0, 0, 8'd200, 4'h9, 4'd0, 32'h000000EE, OK};
    vecs[9] = '{1, 0, 8'h01, 4'h3, 4'd2, 32'h00030201, OK};

    repeat (3) step();
    rst = 1'b0;
    chk("rst_awready", awready, 1);
    chk("rst_arready", arready, 1);
    chk("rst_wready", wready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rlast", rlast, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_bresp", bresp, 0);

    foreach (vecs[i]) begin
      if (vecs[i].wr) do_write(vecs[i]);
      else do_read(vecs[i]);
    end

    // Wrap read 255 -> 0 with beat 0 stalled for three cycles.
    ARADDR = 8'hFF; ARID = 4'hA; ARLEN = 4'd1; ARVALID = 1'b1;
    #1;
    for (int i = 0; i < 20 && !arready; i++) step();
    chk("wrap_arready", arready, 1);
    step();
    ARVALID = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk("stall_rvalid", rvalid, 1);
      chk("stall_rdata", rdata, 8'h22);
      chk("stall_rlast", rlast, 0);
      if (c < 3) step();
    end
    RREADY = 1'b1;
    step();
    chk("wrap_rdata", rdata, 8'h33);
    chk("wrap_rlast", rlast, 1);
    step();
    RREADY = 1'b0;
    chk("wrap_done", rvalid, 0);

    // Simultaneous AW and AR: write wins, read follows in the first IDLE cycle.
    AWADDR = 8'd10; AWID = 4'hB; AWVALID = 1'b1;
    ARADDR = 8'd10; ARID = 4'hC; ARLEN = 4'd0; ARVALID = 1'b1;
    #1;
    chk("prio_awready", awready, 1);
    chk("prio_arready", arready, 0);
    step();
    AWVALID = 1'b0;
    WVALID = 1'b1; WDATA = 8'h5A; WLAST = 1'b1;
    #1;
    chk("prio_wready", wready, 1);
    chk("prio_arready_w", arready, 0);
    step();
    WVALID = 1'b0; WLAST = 1'b0;
    chk("prio_bvalid", bvalid, 1);
    chk("prio_bid", bid, 4'hB);
    BREADY = 1'b1;
    step();
    BREADY = 1'b0;
    chk("prio_arready_idle", arready, 1);
    step();
    ARVALID = 1'b0;
    chk("prio_rvalid", rvalid, 1);
    chk("prio_rdata", rdata, 8'h5A);
    chk("prio_rid", rid, 4'hC);
    chk("prio_rlast", rlast, 1);
    RREADY = 1'b1;
    step();
    RREADY = 1'b0;
    chk("prio_done", rvalid, 0);

    // Reset after beat 1 of a 4-beat read.
    ARADDR = 8'h01; ARID = 4'hD; ARLEN = 4'd3; ARVALID = 1'b1;
    #1;
    for (int i = 0; i < 20 && !arready; i++) step();
    chk("rr_arready", arready, 1);
    step();
    ARVALID = 1'b0; RREADY = 1'b1;
    chk("rr_beat0", rdata, 8'h01);
    step();
    chk("rr_beat1", rdata, 8'h02);
    step();
    chk("rr_beat2", rdata, 8'h03);
    RREADY = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rr_rvalid", rvalid, 0);
    chk("rr_idle", awready, 1);
    do_read('{0, 0, 8'h01, 4'hE, 4'd2, 32'h00030201, OK});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
